qspi_mem_arbiter: RTL and testbench

- Shares the single QSPI memory controller between two requesters: instruction fetch (read-only, word) and the data access stage (load/store, byte/halfword/word).
- Captures the winning request's attributes and issues one command to the QSPI controller.
- Waits for completion with a timeout, then returns a one-cycle valid/finish pulse and the registered read data to the owner.
- Sits between the fetch stage, the data access stage and the QSPI controller.

---
 rtl/qspi_mem_arbiter_pkg.sv | 33 +++
 rtl/qspi_mem_arbiter_if.sv | 50 +++++
 rtl/qspi_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_qspi_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data QSPI memory arbiter.
// State encodings, owner encoding, size codes and the size-decode helper.
package qspi_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [1:0]  SZ_BYTE     = 2'b00;
  localparam logic [1:0]  SZ_HALF     = 2'b01;
  localparam logic [1:0]  SZ_WORD     = 2'b10;
  localparam logic [31:0] TO_DATA_DEF = 32'hDEADBEEF;

  // Word flag takes precedence over the halfword flag.
  function automatic logic [1:0] size_from_flags(input logic w, input logic hw);
    if (w) begin
      return SZ_WORD;
    end else if (hw) begin
      return SZ_HALF;
    end else begin
      return SZ_BYTE;
    end
  endfunction

endpackage

// File: rtl/qspi_mem_arbiter_if.sv
// Bundle of the fetch, data-stage and QSPI controller signals around the arbiter.
// master = arbiter view, slave = the surrounding pipeline / controller view.
interface qspi_mem_arbiter_if;

  logic        i_read_req;
  logic [31:0] i_read_adr;
  logic        i_read_valid;
  logic [31:0] i_read_data;
  logic        d_read_req;
  logic        d_read_w;
  logic        d_read_hw;
  logic [31:0] d_read_adr;
  logic        d_write_req;
  logic        d_write_w;
  logic        d_write_hw;
  logic [31:0] d_write_adr;
  logic [31:0] d_write_data;
  logic        read_valid;
  logic [31:0] read_data;
  logic        write_finish;
  logic        q_req;
  logic        q_we;
  logic [1:0]  q_size;
  logic [31:0] q_adr;
  logic [31:0] q_wdata;
  logic        q_done;
  logic [31:0] q_rdata;
  logic        arb_busy;
  logic        err_timeout;
  logic        err_clr;

  modport master (
    input  i_read_req, i_read_adr,
    input  d_read_req, d_read_w, d_read_hw, d_read_adr,
    input  d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
    input  q_done, q_rdata, err_clr,
    output i_read_valid, i_read_data, read_valid, read_data, write_finish,
    output q_req, q_we, q_size, q_adr, q_wdata, arb_busy, err_timeout
  );

  modport slave (
    output i_read_req, i_read_adr,
    output d_read_req, d_read_w, d_read_hw, d_read_adr,
    output d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
    output q_done, q_rdata, err_clr,
    input  i_read_valid, i_read_data, read_valid, read_data, write_finish,
    input  q_req, q_we, q_size, q_adr, q_wdata, arb_busy, err_timeout
  );

endinterface

// File: rtl/qspi_mem_arbiter.sv
// Arbitrates the single QSPI controller between instruction fetch and the data stage,
// issues one command per grant and returns a one-cycle completion pulse to the owner.
module qspi_mem_arbiter
  import qspi_mem_arbiter_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter logic [15:0] TO_CYC     = 16'd4095,
  parameter logic [31:0] TO_DATA    = TO_DATA_DEF
) (
  input logic               clk,
  input logic               rst_n,
  qspi_mem_arbiter_if.master bus
);

  arb_state_t  r_state;
  arb_state_t  w_next;
  owner_t      r_owner;
  owner_t      r_last_owner;
  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_adr;
  logic [31:0] r_wdata;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_q_req;
  logic        r_busy;
  logic        r_i_valid;
  logic        r_d_valid;
  logic        r_w_finish;

  logic        w_f_pend;
  logic        w_d_pend;
  logic        w_data_win;
  logic        w_grant;
  logic        w_done;
  logic        w_timeout;
  logic        w_new_we;
  logic [1:0]  w_new_size;
  logic [31:0] w_new_adr;
  logic [31:0] w_new_wdata;
  logic [15:0] w_to_last;

  assign w_f_pend  = bus.i_read_req;
  assign w_d_pend  = bus.d_read_req | bus.d_write_req;
  assign w_to_last = TO_CYC - 16'd1;

  // Round-robin hands a tie to whoever was not served last.
  assign w_data_win = FIXED_PRIO ? w_d_pend
                                 : (w_d_pend & (~w_f_pend | (r_last_owner == OWN_FETCH)));

  // Next-state decode.
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_f_pend | w_d_pend) begin
          w_grant = 1'b1;
          w_next  = ST_ISSUE;
        end else begin
          w_next  = ST_IDLE;
        end
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.q_done) begin
          w_done = 1'b1;
          w_next = ST_RESP;
        end else if (r_cnt == w_to_last) begin
          w_timeout = 1'b1;
          w_next    = ST_RESP;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Attributes of the request that would win this cycle; a load beats a store.
  always_comb begin
    w_new_we    = 1'b0;
    w_new_size  = SZ_WORD;
    w_new_adr   = bus.i_read_adr;
    w_new_wdata = 32'h0000_0000;
    if (w_data_win) begin
      if (bus.d_read_req) begin
        w_new_size = size_from_flags(bus.d_read_w, bus.d_read_hw);
        w_new_adr  = bus.d_read_adr;
      end else begin
        w_new_we    = 1'b1;
        w_new_size  = size_from_flags(bus.d_write_w, bus.d_write_hw);
        w_new_adr   = bus.d_write_adr;
        w_new_wdata = bus.d_write_data;
      end
    end else begin
      w_new_we   = 1'b0;
      w_new_size = SZ_WORD;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latched command attributes and ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWN_FETCH;
      r_last_owner <= OWN_FETCH;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_adr        <= 32'h0000_0000;
      r_wdata      <= 32'h0000_0000;
    end else if (w_grant) begin
      r_owner <= w_data_win ? OWN_DATA : OWN_FETCH;
      r_we    <= w_new_we;
      r_size  <= w_new_size;
      r_adr   <= w_new_adr;
      r_wdata <= w_new_wdata;
    end else if (r_state == ST_RESP) begin
      r_last_owner <= r_owner;
    end else begin
      r_last_owner <= r_last_owner;
    end
  end

  // Timeout counter: cleared while issuing, counts while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (r_state == ST_ISSUE) begin
      r_cnt <= 16'd0;
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Read-data register and sticky timeout flag; a new timeout beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      if (w_done) begin
        r_rdata <= bus.q_rdata;
      end else if (w_timeout) begin
        r_rdata <= TO_DATA;
      end else begin
        r_rdata <= r_rdata;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end else begin
        r_err <= r_err;
      end
    end
  end

  // Registered strobes, aligned with the ISSUE and RESP states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_req    <= 1'b0;
      r_busy     <= 1'b0;
      r_i_valid  <= 1'b0;
      r_d_valid  <= 1'b0;
      r_w_finish <= 1'b0;
    end else begin
      r_q_req    <= (w_next == ST_ISSUE);
      r_busy     <= (w_next != ST_IDLE);
      r_i_valid  <= (w_next == ST_RESP) && (r_owner == OWN_FETCH);
      r_d_valid  <= (w_next == ST_RESP) && (r_owner == OWN_DATA) && !r_we;
      r_w_finish <= (w_next == ST_RESP) && (r_owner == OWN_DATA) && r_we;
    end
  end

  assign bus.q_req        = r_q_req;
  assign bus.q_we         = r_we;
  assign bus.q_size       = r_size;
  assign bus.q_adr        = r_adr;
  assign bus.q_wdata      = r_wdata;
  assign bus.i_read_valid = r_i_valid;
  assign bus.i_read_data  = r_rdata;
  assign bus.read_valid   = r_d_valid;
  assign bus.read_data    = r_rdata;
  assign bus.write_finish = r_w_finish;
  assign bus.arb_busy     = r_busy;
  assign bus.err_timeout  = r_err;

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Directed bench: a round-robin DUT and a fixed-priority DUT run in lockstep on shared stimulus.
module tb_qspi_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  qspi_mem_arbiter_if bus0();
  qspi_mem_arbiter_if bus1();

  qspi_mem_arbiter #(.FIXED_PRIO(1'b0), .TO_CYC(16'd8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  qspi_mem_arbiter #(.FIXED_PRIO(1'b1), .TO_CYC(16'd8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus1.i_read_req   = bus0.i_read_req;
  assign bus1.i_read_adr   = bus0.i_read_adr;
  assign bus1.d_read_req   = bus0.d_read_req;
  assign bus1.d_read_w     = bus0.d_read_w;
  assign bus1.d_read_hw    = bus0.d_read_hw;
  assign bus1.d_read_adr   = bus0.d_read_adr;
  assign bus1.d_write_req  = bus0.d_write_req;
  assign bus1.d_write_w    = bus0.d_write_w;
  assign bus1.d_write_hw   = bus0.d_write_hw;
  assign bus1.d_write_adr  = bus0.d_write_adr;
  assign bus1.d_write_data = bus0.d_write_data;
  assign bus1.q_done       = bus0.q_done;
  assign bus1.q_rdata      = bus0.q_rdata;
  assign bus1.err_clr      = bus0.err_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store, 3 load+store together
    logic        w;
    logic        hw;
    logic [31:0] adr;
    logic [31:0] adr2;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        e_we;
    logic [1:0]  e_size;
    logic [31:0] e_adr;
    logic [2:0]  e_pulse; // {i_read_valid, read_valid, write_finish}
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [2:0] pulses0();
    return {bus0.i_read_valid, bus0.read_valid, bus0.write_finish};
  endfunction

  function automatic logic [2:0] pulses1();
    return {bus1.i_read_valid, bus1.read_valid, bus1.write_finish};
  endfunction

  task automatic drop_reqs();
    bus0.i_read_req  = 1'b0;
    bus0.d_read_req  = 1'b0;
    bus0.d_write_req = 1'b0;
  endtask

  task automatic wait_qreq(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.q_req) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (pulses0() != 3'b000) break;
    end
  endtask

  task automatic done_pulse(input logic [31:0] rd);
    bus0.q_done  = 1'b1;
    bus0.q_rdata = rd;
    @(negedge clk);
    bus0.q_done  = 1'b0;
    bus0.q_rdata = 32'h0000_0000;
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_pulses0"}, pulses0(), 3'b000);
    check({tag, "_pulses1"}, pulses1(), 3'b000);
    check({tag, "_rdata"}, {bus0.i_read_data, bus0.read_data}, 64'h0);
    check({tag, "_qbus"}, {bus0.q_req, bus0.q_we, bus0.q_size, bus0.q_adr, bus0.q_wdata}, 68'h0);
    check({tag, "_flags"}, {bus0.arb_busy, bus0.err_timeout, bus1.arb_busy, bus1.err_timeout}, 4'h0);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus0.i_read_req = 1'b0;  bus0.i_read_adr = 32'h0;
    bus0.d_read_req = 1'b0;  bus0.d_read_w = 1'b0;  bus0.d_read_hw = 1'b0;  bus0.d_read_adr = 32'h0;
    bus0.d_write_req = 1'b0; bus0.d_write_w = 1'b0; bus0.d_write_hw = 1'b0; bus0.d_write_adr = 32'h0;
    bus0.d_write_data = 32'h0;
    bus0.q_done = 1'b0; bus0.q_rdata = 32'h0; bus0.err_clr = 1'b0;

    //             kind w     hw    adr           adr2          wdata         dly rdata         we    size   e_adr         pulse
    vecs[0] = '{0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        5, 32'h1234_5678, 1'b0, 2'b10, 32'h0000_0100, 3'b100};
    vecs[1] = '{2, 1'b0, 1'b1, 32'h0000_2002, 32'h0,        32'h0000_ABCD, 3, 32'h0,        1'b1, 2'b01, 32'h0000_2002, 3'b001};
    vecs[2] = '{1, 1'b0, 1'b0, 32'h0000_3003, 32'h0,        32'h0,        2, 32'h0000_00A5, 1'b0, 2'b00, 32'h0000_3003, 3'b010};
    vecs[3] = '{1, 1'b1, 1'b0, 32'h0000_4000, 32'h0,        32'h0,        1, 32'hCAFE_F00D, 1'b0, 2'b10, 32'h0000_4000, 3'b010};
    vecs[4] = '{2, 1'b0, 1'b0, 32'h0000_5001, 32'h0,        32'h0000_0077, 4, 32'h0,        1'b1, 2'b00, 32'h0000_5001, 3'b001};
    vecs[5] = '{1, 1'b0, 1'b1, 32'h0000_6002, 32'h0,        32'h0,        2, 32'h0000_BEEF, 1'b0, 2'b01, 32'h0000_6002, 3'b010};
    vecs[6] = '{3, 1'b1, 1'b0, 32'h0000_7000, 32'h0000_8000, 32'h0000_55AA, 2, 32'h0102_0304, 1'b0, 2'b10, 32'h0000_7000, 3'b010};

    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outs_zero("post_reset");

    // Single-requester transactions from the table.
    for (int i = 0; i < 7; i++) begin
      case (vecs[i].kind)
        0: begin
          bus0.i_read_req = 1'b1; bus0.i_read_adr = vecs[i].adr;
        end
        1, 3: begin
          bus0.d_read_req = 1'b1; bus0.d_read_w = vecs[i].w; bus0.d_read_hw = vecs[i].hw;
          bus0.d_read_adr = vecs[i].adr;
        end
        default: begin
          bus0.d_write_req = 1'b1; bus0.d_write_w = vecs[i].w; bus0.d_write_hw = vecs[i].hw;
          bus0.d_write_adr = vecs[i].adr; bus0.d_write_data = vecs[i].wdata;
        end
      endcase
      if (vecs[i].kind == 3) begin
        bus0.d_write_req = 1'b1; bus0.d_write_adr = vecs[i].adr2; bus0.d_write_data = vecs[i].wdata;
      end
      wait_qreq($sformatf("v%0d_qreq", i));
      check($sformatf("v%0d_we_size_adr", i), {bus0.q_we, bus0.q_size, bus0.q_adr},
            {vecs[i].e_we, vecs[i].e_size, vecs[i].e_adr});
      if (vecs[i].e_we) check($sformatf("v%0d_wdata", i), bus0.q_wdata, vecs[i].wdata);
      repeat (vecs[i].delay) @(negedge clk);
      done_pulse(vecs[i].rdata);
      check($sformatf("v%0d_pulse", i), pulses0(), vecs[i].e_pulse);
      if (vecs[i].kind == 0) check($sformatf("v%0d_i_rdata", i), bus0.i_read_data, vecs[i].rdata);
      if (vecs[i].kind == 1 || vecs[i].kind == 3)
        check($sformatf("v%0d_rdata", i), bus0.read_data, vecs[i].rdata);
      drop_reqs();
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), {pulses0(), bus0.arb_busy}, 4'b0000);
    end

    // Spurious q_done while idle, then attribute changes during WAIT.
    done_pulse(32'hFFFF_0000);
    check("spur_pulse", {pulses0(), bus0.arb_busy}, 4'b0000);
    @(negedge clk);
    check("spur_hold", {pulses0(), bus0.read_data}, {3'b000, 32'h0102_0304});
    bus0.d_read_req = 1'b1; bus0.d_read_w = 1'b0; bus0.d_read_hw = 1'b1; bus0.d_read_adr = 32'h0000_D002;
    wait_qreq("late_qreq");
    check("late_size0", bus0.q_size, 2'b01);
    @(negedge clk);
    check("qreq_one_cycle", bus0.q_req, 1'b0);
    bus0.d_read_w = 1'b1; bus0.d_read_adr = 32'h0000_E000;
    @(negedge clk);
    check("late_latched", {bus0.q_size, bus0.q_adr, bus0.arb_busy}, {2'b01, 32'h0000_D002, 1'b1});
    done_pulse(32'h0000_D00D);
    check("late_pulse", {pulses0(), bus0.read_data}, {3'b010, 32'h0000_D00D});
    drop_reqs(); bus0.d_read_w = 1'b0; bus0.d_read_hw = 1'b0;
    @(negedge clk);

    // Timeout on a load, then clear.
    bus0.d_read_req = 1'b1; bus0.d_read_w = 1'b1; bus0.d_read_adr = 32'h0000_B000;
    wait_qreq("to_qreq");
    wait_pulse(n);
    check("to_latency", n, 9);
    check("to_resp", {pulses0(), bus0.read_data, bus0.err_timeout}, {3'b010, 32'hDEAD_BEEF, 1'b1});
    drop_reqs();
    repeat (3) @(negedge clk);
    check("to_sticky", bus0.err_timeout, 1'b1);
    bus0.err_clr = 1'b1;
    @(negedge clk);
    bus0.err_clr = 1'b0;
    check("to_cleared", bus0.err_timeout, 1'b0);

    // Second timeout with err_clr held high: setting must win.
    bus0.err_clr = 1'b1;
    bus0.d_read_req = 1'b1;
    wait_qreq("to2_qreq");
    wait_pulse(n);
    check("to2_set_wins", {pulses0(), bus0.err_timeout}, {3'b010, 1'b1});
    drop_reqs();
    @(negedge clk);
    check("to2_clr", bus0.err_timeout, 1'b0);
    bus0.err_clr = 1'b0;
    bus0.d_read_w = 1'b0;

    // Reset in WAIT aborts; a fresh fetch afterwards completes cleanly.
    bus0.i_read_req = 1'b1; bus0.i_read_adr = 32'h0000_C000;
    wait_qreq("rst_qreq");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outs_zero("mid_reset");
    bus0.i_read_adr = 32'h0000_C100;
    @(negedge clk);
    rst_n = 1'b1;
    wait_qreq("rst2_qreq");
    check("rst2_no_stale", {pulses0(), bus0.q_adr, bus0.q_size}, {3'b000, 32'h0000_C100, 2'b10});
    repeat (2) @(negedge clk);
    check("rst2_wait_no_pulse", pulses0(), 3'b000);
    done_pulse(32'h0BAD_F00D);
    check("rst2_pulse", {pulses0(), bus0.i_read_data}, {3'b100, 32'h0BAD_F00D});
    drop_reqs();
    @(negedge clk);

    // Contention: both held; round-robin alternates, fixed priority always serves data.
    bus0.i_read_req = 1'b1; bus0.i_read_adr = 32'h0000_A000;
    bus0.d_read_req = 1'b1; bus0.d_read_w = 1'b1; bus0.d_read_adr = 32'h0000_9000;
    for (int k = 0; k < 4; k++) begin
      wait_qreq($sformatf("rr%0d_qreq", k));
      check($sformatf("rr%0d_adr", k), {bus0.q_adr, bus1.q_req, bus1.q_adr},
            {((k % 2) == 0) ? 32'h0000_9000 : 32'h0000_A000, 1'b1, 32'h0000_9000});
      @(negedge clk);
      done_pulse(32'h0000_1000 + k);
      check($sformatf("rr%0d_pulse", k), {pulses0(), pulses1()},
            {((k % 2) == 0) ? 3'b010 : 3'b100, 3'b010});
    end
    drop_reqs();
    @(negedge clk);
    check("rr_idle", {pulses0(), pulses1(), bus0.arb_busy, bus1.arb_busy}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
